qcl_breath_gen: RTL
===================

Name: qcl_breath_gen

Overview:
- Multi-channel, runtime-programmable heartbeat and LED pattern generator.
- Each channel counts its own enable events against a programmable limit. On each period wrap it toggles, pulses, or steps a triangle-ramped PWM duty ("breathing").
- Sits beside status LEDs and debug probes. Configured through a simple one-cycle write port, with no software handshake.

Parameters:
- channels_p, 4, number of independent channels (>=1).
- width_p, 24, width of the per-channel period limit and event counter.
- default_period_p, 'd10_000_000, period limit loaded into every channel at reset; truncated to width_p.
- default_mode_p, 2'd1, mode loaded into every channel at reset.

Ports:
- clk_i, input, 1, single clock.
- reset_i, input, 1, synchronous, active-high reset.
- en_i, input, channels_p, per-channel event enable; one event per cycle when high.
- cfg_v_i, input, 1, configuration write valid; single-cycle strobe with no ready.
- cfg_ch_i, input, $clog2(channels_p) (min 1), target channel of the write.
- cfg_mode_i, input, 2, mode: 0 OFF, 1 TOGGLE, 2 PULSE, 3 BREATH.
- cfg_period_i, input, width_p, new period limit P.
- o, output, channels_p, registered pattern output per channel.
- tick_o, output, channels_p, registered one-cycle pulse per channel, asserted the cycle after a period wrap.

Behaviour:
- Per-channel state:
  - P: width_p bits.
  - M: 2 bits.
  - C: event counter, width_p bits.
  - W: PWM counter, 8 bits.
  - D: duty, 8 bits.
  - dir: 0 = up.
  - o_r and tick_r.
- Reset:
  - P = default_period_p, M = default_mode_p.
  - C = W = D = 0, dir = up.
  - o = 0, tick_o = 0.
- Event: en_i[ch]=1 and M!=OFF.
  - If C==P: wrap, C<=0.
  - Otherwise C<=C+1.
  - A channel therefore wraps every P+1 events. P=0 wraps on every event.
  - No event: all channel state holds and tick_o=0 next cycle.
- tick_o[ch] <= wrap, for every mode except OFF.
- OFF:
  - C, W, D held at 0; o=0, tick_o=0.
  - en_i is ignored.
- TOGGLE: on wrap, o_r <= ~o_r. Output period = 2*(P+1) events.
- PULSE: o_r <= wrap. o is high for exactly one cycle per wrap, coincident with tick_o.
- BREATH:
  - On every event, W <= W+1, wrapping 255->0.
  - o_r <= (W_next < D), where W_next is the value W takes this cycle. o_r updates only on event cycles.
  - On wrap, D steps 1 in direction dir:
    - Going up at D=255: D becomes 254 and dir becomes down.
    - Going down at D=0: D becomes 1 and dir becomes up.
  - One full breath = 510 wraps. D=0 gives o constantly 0.
- Config write (cfg_v_i=1, cfg_ch_i<channels_p):
  - Next cycle, the target channel has P=cfg_period_i and M=cfg_mode_i.
  - C=W=D=0, dir=up, o=0, tick_o=0.
  - The write overrides any event on that channel in the same cycle.
  - Other channels are unaffected.
- cfg_ch_i >= channels_p: write ignored entirely.
- Writing the same values again still restarts the channel (phase reset).
- Reset asserted mid-operation: all channels return to reset state next cycle, including any write that cycle.
- Latency: output change appears 1 cycle after the wrap or write cycle. There is no combinational path from inputs to o or tick_o.
- Channels are fully independent. No shared counters.

Test Plan:
- Reset, defaults overridden by writing ch0 with P=3, TOGGLE, en_i[0]=1 constant:
  - o[0] toggles every 4 cycles: rises 4 cycles after the first enabled cycle.
  - tick_o[0] pulses once every 4 cycles.
- ch1 with P=2 in PULSE, en_i[1] alternating 1/0:
  - o[1] and tick_o[1] pulse high once per 3 enabled cycles, i.e. every 6 clocks.
  - No change on en=0 cycles.
- ch2 with P=0 in BREATH, en_i[2]=1:
  - D increments every cycle; the high-time count per 256-cycle window ramps up.
  - dir flips after D reaches 255 (255 wraps), then D decreases to 0 and rises again.
  - D never goes below 0 or above 255.
- Write to ch0 in the same cycle its C==P with en=1:
  - No toggle occurs; o[0]=0, tick_o[0]=0, C=0 next cycle.
- Write with cfg_ch_i=channels_p (out of range): all channel state unchanged.
- Mode OFF with en_i all 1s for 100 cycles: o=0 and tick_o=0 throughout. Then reset mid-toggle: o returns to 0 next cycle.

Source files
------------

// File: rtl/qcl_breath_gen.sv
// Multi-channel heartbeat / LED pattern generator: per-channel event counter with
// programmable period driving toggle, pulse or triangle-ramped PWM ("breathing") outputs.
module qcl_breath_gen #(
   parameter int unsigned channels_p       = 4,
   parameter int unsigned width_p          = 24,
   parameter int unsigned default_period_p = 32'd10_000_000,
   parameter logic [1:0]  default_mode_p   = 2'd1,
   localparam int unsigned ch_w_lp         = (channels_p > 1) ? $clog2(channels_p) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [channels_p-1:0] en_i,
   input  logic                  cfg_v_i,
   input  logic [ch_w_lp-1:0]    cfg_ch_i,
   input  logic [1:0]            cfg_mode_i,
   input  logic [width_p-1:0]    cfg_period_i,
   output logic [channels_p-1:0] o,
   output logic [channels_p-1:0] tick_o
);

   localparam logic [1:0] mode_off_lp    = 2'd0;
   localparam logic [1:0] mode_toggle_lp = 2'd1;
   localparam logic [1:0] mode_pulse_lp  = 2'd2;
   localparam logic [1:0] mode_breath_lp = 2'd3;

   logic [width_p-1:0] p_q [channels_p];
   logic [width_p-1:0] p_n [channels_p];
   logic [width_p-1:0] c_q [channels_p];
   logic [width_p-1:0] c_n [channels_p];
   logic [1:0]         m_q [channels_p];
   logic [1:0]         m_n [channels_p];
   logic [7:0]         w_q [channels_p];
   logic [7:0]         w_n [channels_p];
   logic [7:0]         d_q [channels_p];
   logic [7:0]         d_n [channels_p];
   logic [channels_p-1:0] dir_q, dir_n;
   logic [channels_p-1:0] o_n, tick_n;

   logic cfg_in_range;
   assign cfg_in_range = 32'(cfg_ch_i) < channels_p;

   // Next-state for every channel; a config write beats any event on its channel
   always_comb begin
      logic       ev;
      logic       wrap;
      logic       hit;
      logic [7:0] w_nx;
      dir_n  = dir_q;
      o_n    = o;
      tick_n = '0;
      for (int unsigned i = 0; i < channels_p; i++) begin
         p_n[i] = p_q[i];
         m_n[i] = m_q[i];
         c_n[i] = c_q[i];
         w_n[i] = w_q[i];
         d_n[i] = d_q[i];
         ev     = en_i[i] && (m_q[i] != mode_off_lp);
         wrap   = ev && (c_q[i] == p_q[i]);
         hit    = cfg_v_i && cfg_in_range && (cfg_ch_i == ch_w_lp'(i));
         w_nx   = w_q[i] + 8'd1;

         if (hit) begin
            p_n[i]    = cfg_period_i;
            m_n[i]    = cfg_mode_i;
            c_n[i]    = '0;
            w_n[i]    = '0;
            d_n[i]    = '0;
            dir_n[i]  = 1'b0;
            o_n[i]    = 1'b0;
            tick_n[i] = 1'b0;
         end else if (m_q[i] == mode_off_lp) begin
            c_n[i]    = '0;
            w_n[i]    = '0;
            d_n[i]    = '0;
            dir_n[i]  = 1'b0;
            o_n[i]    = 1'b0;
         end else begin
            tick_n[i] = wrap;
            if (m_q[i] == mode_pulse_lp) begin
               o_n[i] = wrap;
            end
            if (ev) begin
               c_n[i] = wrap ? '0 : c_q[i] + width_p'(1);
               if (m_q[i] == mode_toggle_lp && wrap) begin
                  o_n[i] = ~o[i];
               end
               if (m_q[i] == mode_breath_lp) begin
                  w_n[i] = w_nx;
                  o_n[i] = w_nx < d_q[i];
                  // Triangle ramp reflects at both ends rather than saturating
                  if (wrap) begin
                     if (!dir_q[i]) begin
                        if (d_q[i] == 8'd255) begin
                           d_n[i]   = 8'd254;
                           dir_n[i] = 1'b1;
                        end else begin
                           d_n[i] = d_q[i] + 8'd1;
                        end
                     end else begin
                        if (d_q[i] == 8'd0) begin
                           d_n[i]   = 8'd1;
                           dir_n[i] = 1'b0;
                        end else begin
                           d_n[i] = d_q[i] - 8'd1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < channels_p; i++) begin
            p_q[i] <= width_p'(default_period_p);
            m_q[i] <= default_mode_p;
            c_q[i] <= '0;
            w_q[i] <= '0;
            d_q[i] <= '0;
         end
         dir_q  <= '0;
         o      <= '0;
         tick_o <= '0;
      end else begin
         for (int unsigned i = 0; i < channels_p; i++) begin
            p_q[i] <= p_n[i];
            m_q[i] <= m_n[i];
            c_q[i] <= c_n[i];
            w_q[i] <= w_n[i];
            d_q[i] <= d_n[i];
         end
         dir_q  <= dir_n;
         o      <= o_n;
         tick_o <= tick_n;
      end
   end

endmodule
